// File: rtl/reaction_timer.sv
// Reaction-test timing stage.
// Counts milliseconds between the start_timer and stop_timer strobes and
// saturates at MAX_MS. When a result is latched it is converted to four BCD
// digits (one double-dabble shift per cycle) and compared with the session
// best time.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start_timer after reset
// RUN     | prescaler and millisecond count advancing
// CONVERT | result latched, double-dabble conversion in progress
// HOLD    | result, digits and best time stable until the next start
module reaction_timer #(
  parameter int CLKS_PER_MS = 10000,
  parameter int MAX_MS      = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_timer,
  input  logic        stop_timer,
  input  logic        clear_best,
  output logic [13:0] elapsed_time,
  output logic        running,
  output logic        timeout,
  output logic        result_valid,
  output logic        bcd_valid,
  output logic [3:0]  bcd_thousands,
  output logic [3:0]  bcd_hundreds,
  output logic [3:0]  bcd_tens,
  output logic [3:0]  bcd_ones,
  output logic [13:0] best_time,
  output logic        best_valid,
  output logic        new_best
);

  localparam int              PW       = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(CLKS_PER_MS - 1);
  localparam logic [13:0]     MAX_VAL  = 14'(MAX_MS);

  typedef enum logic [1:0] {IDLE, RUN, CONVERT, HOLD} state_t;

  state_t        state;
  logic [PW-1:0] prescaler;
  logic [29:0]   shift_reg;
  logic [3:0]    shift_cnt;
  logic [29:0]   dabble_next;
  logic [13:0]   elapsed_inc;

  // One double-dabble step: correct every BCD nibble >= 5, then shift left.
  function automatic logic [29:0] dabble_step(input logic [29:0] sr);
    logic [29:0] adj;
    adj = sr;
    for (int i = 0; i < 4; i++) begin
      if (adj[14 + 4*i +: 4] >= 4'd5)
        adj[14 + 4*i +: 4] = adj[14 + 4*i +: 4] + 4'd3;
    end
    return {adj[28:0], 1'b0};
  endfunction

  // Next conversion step and next millisecond value, both from registered state.
  always_comb begin
    dabble_next = dabble_step(shift_reg);
    elapsed_inc = elapsed_time + 14'd1;
  end

  // Sequencer, counters, result latch, converter and best-time tracker.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      prescaler     <= '0;
      shift_reg     <= '0;
      shift_cnt     <= '0;
      elapsed_time  <= '0;
      running       <= 1'b0;
      timeout       <= 1'b0;
      result_valid  <= 1'b0;
      bcd_valid     <= 1'b0;
      bcd_thousands <= '0;
      bcd_hundreds  <= '0;
      bcd_tens      <= '0;
      bcd_ones      <= '0;
      best_time     <= '0;
      best_valid    <= 1'b0;
      new_best      <= 1'b0;
    end else begin
      result_valid <= 1'b0;

      // A best-time update further down overrides this clear.
      if (clear_best) begin
        best_time  <= '0;
        best_valid <= 1'b0;
        new_best   <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start_timer) begin
            state        <= RUN;
            running      <= 1'b1;
            prescaler    <= '0;
            elapsed_time <= '0;
            timeout      <= 1'b0;
            new_best     <= 1'b0;
          end
        end

        RUN: begin
          if (start_timer) begin
            // Restart; start also wins over a coincident stop.
            prescaler    <= '0;
            elapsed_time <= '0;
            timeout      <= 1'b0;
            new_best     <= 1'b0;
          end else if (stop_timer) begin
            // Stop wins over a coincident ms tick: elapsed_time is frozen as is.
            state        <= CONVERT;
            running      <= 1'b0;
            result_valid <= 1'b1;
            shift_reg    <= {16'd0, elapsed_time};
            shift_cnt    <= '0;
            if (!best_valid || (elapsed_time < best_time)) begin
              best_time  <= elapsed_time;
              best_valid <= 1'b1;
              new_best   <= 1'b1;
            end else begin
              new_best   <= 1'b0;
            end
          end else if (prescaler == PRE_LAST) begin
            prescaler <= '0;
            if (elapsed_inc >= MAX_VAL) begin
              // Timeout: saturate and convert, leaving the best record alone.
              elapsed_time <= MAX_VAL;
              timeout      <= 1'b1;
              state        <= CONVERT;
              running      <= 1'b0;
              result_valid <= 1'b1;
              shift_reg    <= {16'd0, MAX_VAL};
              shift_cnt    <= '0;
            end else begin
              elapsed_time <= elapsed_inc;
            end
          end else begin
            prescaler <= prescaler + 1'b1;
          end
        end

        CONVERT: begin
          shift_reg <= dabble_next;
          shift_cnt <= shift_cnt + 4'd1;
          // The 14th shift lands the final digits in the BCD field.
          if (shift_cnt == 4'd13) begin
            bcd_thousands <= dabble_next[29:26];
            bcd_hundreds  <= dabble_next[25:22];
            bcd_tens      <= dabble_next[21:18];
            bcd_ones      <= dabble_next[17:14];
            bcd_valid     <= 1'b1;
            state         <= HOLD;
          end
        end

        HOLD: begin
          if (start_timer) begin
            state        <= RUN;
            running      <= 1'b1;
            bcd_valid    <= 1'b0;
            prescaler    <= '0;
            elapsed_time <= '0;
            timeout      <= 1'b0;
            new_best     <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_timer.sv
// Self-checking bench for reaction_timer with a 4-cycle millisecond tick.
// Expected values come from a reference model: result = plain run cycles / 4,
// digits by decimal division, best time as a running minimum.
module tb_reaction_timer;

  localparam int CLKS = 4;
  localparam int MAXV = 9999;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_timer = 1'b0;
  logic        stop_timer = 1'b0;
  logic        clear_best = 1'b0;
  logic [13:0] elapsed_time;
  logic        running;
  logic        timeout;
  logic        result_valid;
  logic        bcd_valid;
  logic [3:0]  bcd_thousands;
  logic [3:0]  bcd_hundreds;
  logic [3:0]  bcd_tens;
  logic [3:0]  bcd_ones;
  logic [13:0] best_time;
  logic        best_valid;
  logic        new_best;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model of the best-time record.
  int m_best       = 0;
  bit m_best_valid = 1'b0;
  bit m_new_best   = 1'b0;

  reaction_timer #(.CLKS_PER_MS(CLKS), .MAX_MS(MAXV)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_timer  (start_timer),
    .stop_timer   (stop_timer),
    .clear_best   (clear_best),
    .elapsed_time (elapsed_time),
    .running      (running),
    .timeout      (timeout),
    .result_valid (result_valid),
    .bcd_valid    (bcd_valid),
    .bcd_thousands(bcd_thousands),
    .bcd_hundreds (bcd_hundreds),
    .bcd_tens     (bcd_tens),
    .bcd_ones     (bcd_ones),
    .best_time    (best_time),
    .best_valid   (best_valid),
    .new_best     (new_best)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_digits(input string tag, input int r);
    check({tag, "_thou"}, 32'(bcd_thousands), 32'((r / 1000) % 10));
    check({tag, "_hund"}, 32'(bcd_hundreds),  32'((r / 100) % 10));
    check({tag, "_tens"}, 32'(bcd_tens),      32'((r / 10) % 10));
    check({tag, "_ones"}, 32'(bcd_ones),      32'(r % 10));
  endtask

  task automatic check_best(input string tag);
    check({tag, "_best"},   32'(best_time),  32'(m_best));
    check({tag, "_bvalid"}, 32'(best_valid), 32'(m_best_valid));
    check({tag, "_newbest"},32'(new_best),   32'(m_new_best));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_elapsed"}, 32'(elapsed_time), 0);
    check({tag, "_running"}, 32'(running), 0);
    check({tag, "_timeout"}, 32'(timeout), 0);
    check({tag, "_rv"},      32'(result_valid), 0);
    check({tag, "_bcdv"},    32'(bcd_valid), 0);
    check_digits(tag, 0);
    check({tag, "_best"},    32'(best_time), 0);
    check({tag, "_bvalid"},  32'(best_valid), 0);
    check({tag, "_newbest"}, 32'(new_best), 0);
  endtask

  // Start, let n plain cycles pass, then stop. clr_at in 0..n-1 pulses
  // clear_best on that plain cycle; clr_at == n pulses it with the stop.
  task automatic do_run(input int n, input int clr_at, input string tag);
    int r;
    start_timer = 1'b1; tick(); start_timer = 1'b0;
    m_new_best = 1'b0;
    check({tag, "_start_run"}, 32'(running), 1);
    check({tag, "_start_el"},  32'(elapsed_time), 0);
    for (int i = 0; i < n; i++) begin
      clear_best = (i == clr_at);
      tick();
      if (i == clr_at) begin
        m_best = 0; m_best_valid = 1'b0; m_new_best = 1'b0;
      end
    end
    clear_best = 1'b0;
    r = n / CLKS;
    check({tag, "_live"}, 32'(elapsed_time), 32'(r));
    stop_timer = 1'b1;
    clear_best = (clr_at == n);
    tick();
    stop_timer = 1'b0;
    clear_best = 1'b0;
    if (!m_best_valid || r < m_best) begin
      m_best = r; m_best_valid = 1'b1; m_new_best = 1'b1;
    end else begin
      m_new_best = 1'b0;
      if (clr_at == n) begin m_best = 0; m_best_valid = 1'b0; end
    end
    check({tag, "_rv"},      32'(result_valid), 1);
    check({tag, "_result"},  32'(elapsed_time), 32'(r));
    check({tag, "_stopped"}, 32'(running), 0);
    check({tag, "_timeout"}, 32'(timeout), 0);
    check_best(tag);
    tick();
    check({tag, "_rv_pulse"}, 32'(result_valid), 0);
    repeat (12) tick();
    check({tag, "_bcdv_early"}, 32'(bcd_valid), 0);
    tick();
    check({tag, "_bcdv"}, 32'(bcd_valid), 1);
    check_digits(tag, r);
    check({tag, "_hold_el"}, 32'(elapsed_time), 32'(r));
  endtask

  initial begin
    int n;
    int c;

    // Reset held two cycles with start asserted.
    reset = 1'b1; start_timer = 1'b1;
    tick(); tick();
    check_all_zero("reset");
    reset = 1'b0; start_timer = 1'b0;
    tick();
    stop_timer = 1'b1; tick(); stop_timer = 1'b0;
    check("idle_stop_rv", 32'(result_valid), 0);
    check("idle_stop_run", 32'(running), 0);

    // Basic run and best tracking: 37, 52, 37 (tie), 20.
    do_run(148, -1, "run37");
    do_run(208, -1, "run52");
    do_run(148, -1, "run37b");
    do_run(80,  -1, "run20");

    // Stop while prescaler = 3 and elapsed = 5: tick suppressed.
    do_run(23, -1, "edge5");

    // Timeout: no stop for 9999 ms.
    start_timer = 1'b1; tick(); start_timer = 1'b0;
    repeat (MAXV * CLKS - 1) tick();
    check("to_before", 32'(elapsed_time), 32'(MAXV - 1));
    check("to_run_before", 32'(running), 1);
    tick();
    check("to_el", 32'(elapsed_time), 32'(MAXV));
    check("to_flag", 32'(timeout), 1);
    check("to_rv", 32'(result_valid), 1);
    check("to_running", 32'(running), 0);
    m_new_best = 1'b0;
    check_best("to");
    stop_timer = 1'b1; tick(); stop_timer = 1'b0;
    check("to_stop_ignored", 32'(result_valid), 0);
    repeat (12) tick();
    check("to_bcdv_early", 32'(bcd_valid), 0);
    tick();
    check("to_bcdv", 32'(bcd_valid), 1);
    check_digits("to", MAXV);
    stop_timer = 1'b1; tick(); stop_timer = 1'b0;
    check("to_hold_stop_rv", 32'(result_valid), 0);
    check("to_hold_el", 32'(elapsed_time), 32'(MAXV));
    check("to_hold_flag", 32'(timeout), 1);

    // Randomized runs, some with clear_best mid-run or coincident with stop.
    for (int k = 0; k < 12; k++) begin
      n = int'($urandom_range(0, 300));
      c = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n)) : -1;
      do_run(n, c, $sformatf("rnd%0d", k));
    end

    // Start and stop together in RUN: restart, no result.
    start_timer = 1'b1; tick(); start_timer = 1'b0;
    repeat (30) tick();
    start_timer = 1'b1; stop_timer = 1'b1; tick();
    start_timer = 1'b0; stop_timer = 1'b0;
    check("ss_running", 32'(running), 1);
    check("ss_el", 32'(elapsed_time), 0);
    check("ss_rv", 32'(result_valid), 0);
    repeat (10) tick();
    check("ss_live", 32'(elapsed_time), 32'(10 / CLKS));

    // Finish with a full run, then clear_best in HOLD keeps the digits.
    do_run(57, -1, "pre_clr");
    clear_best = 1'b1; tick(); clear_best = 1'b0;
    m_best = 0; m_best_valid = 1'b0; m_new_best = 1'b0;
    check_best("clr_hold");
    check("clr_hold_bcdv", 32'(bcd_valid), 1);
    check_digits("clr_hold", 57 / CLKS);

    // Reset in the middle of a conversion.
    start_timer = 1'b1; tick(); start_timer = 1'b0;
    repeat (90) tick();
    stop_timer = 1'b1; tick(); stop_timer = 1'b0;
    repeat (5) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check_all_zero("rst_conv");
    repeat (14) tick();
    check("rst_conv_bcdv_late", 32'(bcd_valid), 0);
    check_digits("rst_conv_late", 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
- Downstream timing stage of the reaction-test FSM. It consumes that FSM's start_timer and stop_timer strobes and returns elapsed_time, a saturating 14-bit millisecond count (0..9999).
- On stop, it latches the result, converts it to four BCD digits for the 7-segment display path, and tracks the session best time.
- Auto-terminates at 9999 ms and flags a timeout.

Parameters:
- CLKS_PER_MS, 10000, clock cycles per millisecond tick (10 MHz clock); must be ≥2.
- MAX_MS, 9999, saturation value of the millisecond count.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start_timer  input  1  one-cycle strobe: clear and begin counting.
- stop_timer  input  1  one-cycle strobe: freeze and latch result.
- clear_best  input  1  clears the best-time record.
- elapsed_time  output  14  live ms count in RUN; latched result otherwise.
- running  output  1  high in RUN.
- timeout  output  1  result reached MAX_MS without stop.
- result_valid  output  1  one-cycle pulse when a result is latched.
- bcd_valid  output  1  BCD digits stable.
- bcd_thousands, bcd_hundreds, bcd_tens, bcd_ones  output  4 each  BCD of the latched result.
- best_time  output  14  smallest non-timeout result since reset/clear_best.
- best_valid  output  1  best_time holds a real result.
- new_best  output  1  last result set a new best.

Behaviour:
- Reset (synchronous, wins over all inputs):
  - State = IDLE.
  - Prescaler = 0.
  - Every output = 0, including best_time and all BCD digits.
- States: IDLE, RUN, CONVERT, HOLD. All registered, single clock.
- IDLE:
  - start_timer → RUN; elapsed_time, prescaler, timeout and new_best cleared on the same edge.
  - stop_timer ignored.
- RUN (running = 1):
  - Prescaler counts 0..CLKS_PER_MS-1 and wraps to 0.
  - On the wrap edge, elapsed_time increments by 1.
  - If that increment reaches MAX_MS: result latched as MAX_MS, timeout = 1, result_valid pulses, state → CONVERT. Best time is not touched.
  - stop_timer sampled at edge k:
    - Latch the current elapsed_time. Stop beats a coincident ms tick, so the increment is suppressed.
    - result_valid = 1 for cycle k+1 only; state → CONVERT.
    - If best_valid = 0 or result < best_time: best_time ← result, best_valid ← 1, new_best ← 1. Otherwise new_best ← 0.
    - A result equal to best_time does not count as a new best.
  - start_timer in RUN restarts: elapsed = 0, prescaler = 0, stays in RUN.
  - start and stop in the same cycle: start wins.
- CONVERT (double-dabble, one shift per cycle):
  - Loaded at edge k with a 30-bit shift register: 16 BCD bits = 0, 14 binary bits = result.
  - Edges k+1..k+14 each: add 3 to any BCD nibble ≥ 5, then shift left 1.
  - At edge k+14 the digits register, bcd_valid ← 1, state → HOLD.
  - bcd_valid therefore rises exactly 14 cycles after the stop-sampling edge.
  - start_timer and stop_timer are ignored in CONVERT.
- HOLD:
  - elapsed_time, timeout, the digits and new_best are held.
  - start_timer → RUN, with bcd_valid ← 0 and the IDLE clears applied.
  - stop_timer ignored.
- clear_best:
  - Any state: best_time ← 0, best_valid ← 0, new_best ← 0 on the next edge.
  - If coincident with a best update on that edge, the update wins.
- Width rules:
  - elapsed_time never exceeds MAX_MS.
  - Prescaler width is clog2(CLKS_PER_MS).
  - All comparisons unsigned.
- Reset mid-RUN or mid-CONVERT: immediate return to IDLE with all outputs 0; no partial digits are exposed.

Test Plan:
- Reset:
  - Assert reset 2 cycles with start_timer = 1 → all outputs 0, state IDLE.
  - stop_timer pulse in IDLE → no result_valid.
- Basic run (CLKS_PER_MS = 4):
  - start, wait 148 cycles, stop → elapsed_time = 37 and result_valid pulse.
  - 14 cycles later: bcd_valid = 1 with digits 0,0,3,7.
  - best_time = 37, best_valid = 1, new_best = 1.
- Best tracking:
  - Runs of 52 then 37 → best_time stays 37, new_best = 0 on both.
  - Next run of 20 → best_time = 20, new_best = 1.
- Timeout:
  - start with no stop for 9999×4 cycles → elapsed_time = 9999, timeout = 1, result_valid pulse.
  - Digits 9,9,9,9; best unchanged.
  - A later stop_timer is ignored.
- Boundaries:
  - stop on the cycle where prescaler = 3 and elapsed_time = 5 → result 5, not 6.
  - start + stop in the same RUN cycle → restart to 0, no result_valid.
- Clears:
  - clear_best in HOLD → best_time = 0, best_valid = 0, digits retained.
  - reset during CONVERT → bcd_valid remains 0, all digits 0.
